input_debouncer: RTL and testbench

- Conditions a raw asynchronous level input before it reaches the dff data-flop stage.
- Synchronises the input into the clk domain, rejects glitches shorter than a programmable window, and presents a clean level with its complement.
- Also produces single-cycle rise/fall strobes.
- Output dout drives the downstream dff d input directly.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_chain.sv | 34 +++
 rtl/input_debouncer.sv | 119 +++++++++++
 tb/tb_input_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, defaults and helpers for input_debouncer.
//   db_state_t : qualification FSM states (STABLE, CHECK)
//   db_cnt_w   : qualification counter width for a given window length
//   DEF_*      : default parameter values
package debounce_pkg;

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} db_state_t;

  localparam int   DEF_SYNC_STAGES     = 2;
  localparam int   DEF_DEBOUNCE_CYCLES = 4;
  localparam logic DEF_RESET_VALUE     = 1'b0;

  // Counter must hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int db_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous level input.
// Ports:
//   clk     in  clock
//   reset_n in  asynchronous active-low reset (loads RESET_VALUE)
//   d       in  asynchronous level
//   q       out synchronised level (last stage)
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_param_check
    $error("sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the flop chain; index 0 is the metastable stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw level, rejects glitches shorter than
// DEBOUNCE_CYCLES samples and presents a clean level plus edge strobes.
// Ports:
//   clk     in  clock
//   reset_n in  asynchronous active-low reset
//   din     in  raw asynchronous level
//   enable  in  1 = qualify changes, 0 = freeze dout and drop pending change
//   dout    out debounced level (registered)
//   dout_b  out complement of dout (registered)
//   rise    out one-cycle strobe on committed 0->1
//   fall    out one-cycle strobe on committed 1->0
//   busy    out candidate change under qualification
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VALUE     = DEF_RESET_VALUE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic dout_b,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("input_debouncer: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  localparam int                CNT_W    = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync_level;
  db_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       dout_q;
  logic       dout_b_q;
  logic       rise_q;
  logic       fall_q;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (sync_level)
  );

  // Qualification FSM, counter and all registered outputs.
  // The CHECK state counts the sample that entered it as sample 1, so a
  // commit happens on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= STABLE;
      cnt_q    <= CNT_ZERO;
      dout_q   <= RESET_VALUE;
      dout_b_q <= ~RESET_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (enable && (sync_level != dout_q)) begin
            if (DEBOUNCE_CYCLES == 1) begin
              dout_q   <= sync_level;
              dout_b_q <= ~sync_level;
              rise_q   <= sync_level;
              fall_q   <= ~sync_level;
            end else begin
              state_q <= CHECK;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        CHECK: begin
          if (!enable) begin
            state_q <= STABLE;
            cnt_q   <= CNT_ZERO;
          end else if (sync_level == dout_q) begin
            // Input returned to the committed level: glitch dropped.
            state_q <= STABLE;
            cnt_q   <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= STABLE;
            cnt_q    <= CNT_ZERO;
            dout_q   <= sync_level;
            dout_b_q <= ~sync_level;
            rise_q   <= sync_level;
            fall_q   <= ~sync_level;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign dout   = dout_q;
  assign dout_b = dout_b_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign busy   = (state_q == CHECK);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance (a) and a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance (b) sharing clock and reset.
module tb_input_debouncer;

  logic clk;
  logic reset_n;
  logic a_din, a_en, a_dout, a_dout_b, a_rise, a_fall, a_busy;
  logic b_din, b_en, b_dout, b_dout_b, b_rise, b_fall, b_busy;

  int checks;
  int failures;

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (1'b0)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (a_din),
    .enable  (a_en),
    .dout    (a_dout),
    .dout_b  (a_dout_b),
    .rise    (a_rise),
    .fall    (a_fall),
    .busy    (a_busy)
  );

  input_debouncer #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1),
    .RESET_VALUE     (1'b0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (b_din),
    .enable  (b_en),
    .dout    (b_dout),
    .dout_b  (b_dout_b),
    .rise    (b_rise),
    .fall    (b_fall),
    .busy    (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic e_dout, input logic e_rise,
                         input logic e_fall, input logic e_busy);
    check({tag, "_dout"},   a_dout,   e_dout);
    check({tag, "_dout_b"}, a_dout_b, ~e_dout);
    check({tag, "_rise"},   a_rise,   e_rise);
    check({tag, "_fall"},   a_fall,   e_fall);
    check({tag, "_busy"},   a_busy,   e_busy);
  endtask

  task automatic check_b(input string tag, input logic e_dout, input logic e_rise,
                         input logic e_fall);
    check({tag, "_b_dout"},   b_dout,   e_dout);
    check({tag, "_b_dout_b"}, b_dout_b, ~e_dout);
    check({tag, "_b_rise"},   b_rise,   e_rise);
    check({tag, "_b_fall"},   b_fall,   e_fall);
    check({tag, "_b_busy"},   b_busy,   1'b0);
  endtask

  initial begin
    logic lvl;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    a_din    = 1'b1;
    a_en     = 1'b1;
    b_din    = 1'b0;
    b_en     = 1'b1;
    #1;

    // Reset held with din=1: everything stays at reset values.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      check_b("rst_hold", 1'b0, 1'b0, 1'b0);
    end

    // Release: din=1 already settled at the pin, commit after edge 5.
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_a("rel_rise", (k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4));
    end

    // 1->0 held: fall pulse after edge 5.
    a_din = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_a("fall", (k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4));
    end

    // Glitch: din high for edges 0..2 only, never committed.
    a_din = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) a_din = 1'b0;
      tick();
      check_a("glitch", 1'b0, 1'b0, 1'b0, (k >= 2 && k <= 4));
    end

    // 0->1 held: rise pulse after edge 5.
    a_din = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_a("rise", (k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4));
    end

    // Return to 0 before the enable test.
    a_din = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check_a("pre_en", 1'b0, 1'b0, 1'b0, 1'b0);

    // Disabled: a held change is ignored for 20 cycles.
    a_en  = 1'b0;
    a_din = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_a("disabled", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Enable with s already settled: full window, commit on 4th edge.
    a_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_a("en_rise", (k >= 3), (k == 3), 1'b0, (k <= 2));
    end

    // Reset mid-CHECK (cnt=2) while qualifying a 1->0 change.
    a_din = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_a("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_a("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a("mid_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_a("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Instance b: single-sample window behind 3 sync stages.
    b_din = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_b("b_rise", (k >= 3), (k == 3), 1'b0);
    end

    // Toggle every 4 cycles: alternating fall/rise pulses.
    lvl = 1'b1;
    for (int t = 0; t < 4; t++) begin
      lvl   = ~lvl;
      b_din = lvl;
      for (int k = 0; k < 4; k++) begin
        tick();
        check_b("b_toggle", (k >= 3) ? lvl : ~lvl, (k == 3) && lvl, (k == 3) && !lvl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
